// File: rtl/routing_unit_pipelined.sv
// routing_unit_pipelined: per-input-channel registered route computation for
// one mesh router at (X_LOC, Y_LOC). Each head-flit request produces a
// candidate direction set (XY, odd-even or west-first). The set is offered to
// the selection stage with a valid/ack handshake. The channel then stays busy
// until the packet's tail has left.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_mode          routing mode (0=XY, 1=odd-even, 2=west-first, 3=XY)
//   i_route_req     per-channel head-flit request (single-cycle)
//   i_x_source      per-channel packet source column
//   i_x_dest        per-channel destination column
//   i_y_dest        per-channel destination row
//   i_route_ack     selection stage consumed the route
//   i_tail_done     tail flit of the current packet has left the channel
//   o_route_valid   route result valid
//   o_avail_mask    candidate directions {W,S,E,N}
//   o_local         destination is this node
//   o_avail_count   popcount(mask) + local
//   o_route_err     destination outside the mesh
//   o_busy          channel not idle
//   o_stall         route offered for >= STALL_TH cycles without ack
//   o_req_err       sticky: request arrived while channel busy
module routing_unit_pipelined #(
  parameter int unsigned X_NODES  = 4,
  parameter int unsigned Y_NODES  = 4,
  parameter int unsigned X_LOC    = 0,
  parameter int unsigned Y_LOC    = 0,
  parameter int unsigned N        = 5,
  parameter int unsigned STALL_TH = 16,
  parameter int unsigned SW       = 5,
  localparam int unsigned XW      = (X_NODES > 1) ? $clog2(X_NODES) : 1,
  localparam int unsigned YW      = (Y_NODES > 1) ? $clog2(Y_NODES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             i_mode,
  input  logic [N-1:0]           i_route_req,
  input  logic [N-1:0][XW-1:0]   i_x_source,
  input  logic [N-1:0][XW-1:0]   i_x_dest,
  input  logic [N-1:0][YW-1:0]   i_y_dest,
  input  logic [N-1:0]           i_route_ack,
  input  logic [N-1:0]           i_tail_done,
  output logic [N-1:0]           o_route_valid,
  output logic [N-1:0][3:0]      o_avail_mask,
  output logic [N-1:0]           o_local,
  output logic [N-1:0][2:0]      o_avail_count,
  output logic [N-1:0]           o_route_err,
  output logic [N-1:0]           o_busy,
  output logic [N-1:0]           o_stall,
  output logic [N-1:0]           o_req_err
);

  // State encoding doubles as registered outputs: bit1 = valid, bit0 = busy.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HOLD  = 2'b01,
    VALID = 2'b11
  } state_e;

  localparam logic [3:0]    DIR_N   = 4'b0001;
  localparam logic [3:0]    DIR_E   = 4'b0010;
  localparam logic [3:0]    DIR_S   = 4'b0100;
  localparam logic [3:0]    DIR_W   = 4'b1000;
  localparam logic          LX_ODD  = ((X_LOC % 2) == 1);
  localparam logic [SW-1:0] AGE_MAX = '1;

  for (genvar g = 0; g < int'(N); g++) begin : g_ch
    state_e        state_q;
    logic [3:0]    mask_q;
    logic          local_q;
    logic [2:0]    count_q;
    logic          err_q;
    logic          stall_q;
    logic          req_err_q;
    logic [SW-1:0] age_q;

    int unsigned   xd;
    int unsigned   yd;
    int unsigned   xs;
    logic [3:0]    ns_c;
    logic [3:0]    mask_c;
    logic          local_c;
    logic          err_c;
    logic [2:0]    count_c;
    logic [SW-1:0] age_inc_c;
    logic          accept_c;

    // Route function for the request currently presented on this channel.
    always_comb begin : route_calc
      xd      = 32'(i_x_dest[g]);
      yd      = 32'(i_y_dest[g]);
      xs      = 32'(i_x_source[g]);
      mask_c  = '0;
      local_c = 1'b0;
      err_c   = 1'b0;
      ns_c    = (yd > Y_LOC) ? DIR_N : ((yd < Y_LOC) ? DIR_S : 4'b0000);
      if (xd >= X_NODES || yd >= Y_NODES) begin
        err_c = 1'b1;
      end else if (xd == X_LOC && yd == Y_LOC) begin
        local_c = 1'b1;
      end else begin
        case (i_mode)
          2'd1: begin
            // Odd-even: turn restrictions depend on column parity.
            if (xd == X_LOC) begin
              mask_c = ns_c;
            end else if (xd > X_LOC) begin
              if (yd == Y_LOC) begin
                mask_c = DIR_E;
              end else begin
                if (LX_ODD || xs == X_LOC) mask_c = mask_c | ns_c;
                if (i_x_dest[g][0] || (xd - X_LOC) != 1) mask_c = mask_c | DIR_E;
              end
            end else begin
              mask_c = DIR_W;
              if (!LX_ODD) mask_c = mask_c | ns_c;
            end
          end
          2'd2: begin
            // West-first: any westward hop must be taken before others.
            if (xd < X_LOC) begin
              mask_c = DIR_W;
            end else begin
              mask_c = ns_c;
              if (xd > X_LOC) mask_c = mask_c | DIR_E;
            end
          end
          default: begin
            if (xd > X_LOC)      mask_c = DIR_E;
            else if (xd < X_LOC) mask_c = DIR_W;
            else                 mask_c = ns_c;
          end
        endcase
      end
      count_c = 3'(mask_c[0]) + 3'(mask_c[1]) + 3'(mask_c[2]) + 3'(mask_c[3])
              + 3'(local_c);
    end

    // Saturating age increment and request acceptance (idle, or tail freeing HOLD).
    always_comb begin : ctl_calc
      age_inc_c = (age_q == AGE_MAX) ? age_q : age_q + SW'(1);
      accept_c  = i_route_req[g] &&
                  ((state_q == IDLE) || (state_q == HOLD && i_tail_done[g]));
    end

    // Channel FSM; age_q counts VALID cycles including the current one.
    always_ff @(posedge clk) begin : ch_fsm
      if (reset) begin
        state_q   <= IDLE;
        mask_q    <= '0;
        local_q   <= 1'b0;
        count_q   <= '0;
        err_q     <= 1'b0;
        stall_q   <= 1'b0;
        req_err_q <= 1'b0;
        age_q     <= '0;
      end else begin
        stall_q <= 1'b0;
        if (i_route_req[g] && !accept_c) req_err_q <= 1'b1;
        if (accept_c) begin
          state_q <= VALID;
          mask_q  <= mask_c;
          local_q <= local_c;
          count_q <= count_c;
          err_q   <= err_c;
          age_q   <= SW'(1);
          stall_q <= (STALL_TH <= 1);
        end else begin
          case (state_q)
            VALID: begin
              if (i_route_ack[g]) begin
                state_q <= i_tail_done[g] ? IDLE : HOLD;
              end else begin
                age_q   <= age_inc_c;
                stall_q <= (32'(age_inc_c) >= STALL_TH);
              end
            end
            HOLD: begin
              if (i_tail_done[g]) state_q <= IDLE;
            end
            IDLE: begin
              state_q <= IDLE;
            end
            default: begin
              state_q <= IDLE;
            end
          endcase
        end
      end
    end

    assign o_route_valid[g] = state_q[1];
    assign o_busy[g]        = state_q[0];
    assign o_avail_mask[g]  = mask_q;
    assign o_local[g]       = local_q;
    assign o_avail_count[g] = count_q;
    assign o_route_err[g]   = err_q;
    assign o_stall[g]       = stall_q;
    assign o_req_err[g]     = req_err_q;
  end

endmodule

// File: tb/tb_routing_unit_pipelined.sv
// Testbench for routing_unit_pipelined: scoreboard of expected route results,
// directed handshake/stall/error scenarios plus randomised routes.
module tb_routing_unit_pipelined;

  localparam int XN  = 6;
  localparam int YN  = 8;
  localparam int XL  = 2;
  localparam int YL  = 3;
  localparam int NC  = 3;
  localparam int STH = 3;
  localparam int SWD = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           mode;
  logic [NC-1:0]        req;
  logic [NC-1:0][2:0]   xsrc;
  logic [NC-1:0][2:0]   xdst;
  logic [NC-1:0][2:0]   ydst;
  logic [NC-1:0]        ack;
  logic [NC-1:0]        tail;
  logic [NC-1:0]        valid;
  logic [NC-1:0][3:0]   mask;
  logic [NC-1:0]        loc;
  logic [NC-1:0][2:0]   cnt;
  logic [NC-1:0]        rerr;
  logic [NC-1:0]        busy;
  logic [NC-1:0]        stall;
  logic [NC-1:0]        qerr;

  always #5 clk = ~clk;

  routing_unit_pipelined #(
    .X_NODES(XN), .Y_NODES(YN), .X_LOC(XL), .Y_LOC(YL),
    .N(NC), .STALL_TH(STH), .SW(SWD)
  ) dut (
    .clk(clk), .reset(reset), .i_mode(mode),
    .i_route_req(req), .i_x_source(xsrc), .i_x_dest(xdst), .i_y_dest(ydst),
    .i_route_ack(ack), .i_tail_done(tail),
    .o_route_valid(valid), .o_avail_mask(mask), .o_local(loc),
    .o_avail_count(cnt), .o_route_err(rerr), .o_busy(busy),
    .o_stall(stall), .o_req_err(qerr)
  );

  typedef struct packed {
    logic [1:0] ch;
    logic       err;
    logic       loc;
    logic [2:0] cnt;
    logic [3:0] mask;
  } exp_t;

  typedef struct {
    int md; int xs; int xd; int yd;
    int mask; int loc; int cnt; int err;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference route model, written in signed-offset form.
  function automatic exp_t model(int ch, int md, int xs, int xd, int yd);
    exp_t e;
    int dx, dy;
    logic [3:0] v, ns;
    e = '0;
    e.ch = 2'(ch);
    dx = xd - XL;
    dy = yd - YL;
    ns = (dy > 0) ? 4'b0001 : ((dy < 0) ? 4'b0100 : 4'b0000);
    if (xd >= XN || yd >= YN) begin
      e.err = 1'b1;
      return e;
    end
    if (dx == 0 && dy == 0) begin
      e.loc = 1'b1;
      e.cnt = 3'd1;
      return e;
    end
    v = 4'b0000;
    if (md == 1) begin
      if (dx == 0) v = ns;
      else if (dx > 0) begin
        if (dy == 0) v = 4'b0010;
        else begin
          if ((XL % 2) == 1 || xs == XL) v = v | ns;
          if ((xd % 2) == 1 || dx != 1) v = v | 4'b0010;
        end
      end else begin
        v = 4'b1000;
        if ((XL % 2) == 0) v = v | ns;
      end
    end else if (md == 2) begin
      if (dx < 0) v = 4'b1000;
      else begin
        v = ns;
        if (dx > 0) v = v | 4'b0010;
      end
    end else begin
      if (dx > 0)      v = 4'b0010;
      else if (dx < 0) v = 4'b1000;
      else             v = ns;
    end
    e.mask = v;
    e.cnt  = 3'($countones(v));
    return e;
  endfunction

  task automatic issue(input int ch, input int md, input int xs, input int xd,
                       input int yd, input logic tl, input exp_t e);
    mode     = 2'(md);
    xsrc[ch] = 3'(xs);
    xdst[ch] = 3'(xd);
    ydst[ch] = 3'(yd);
    req[ch]  = 1'b1;
    tail[ch] = tl;
    sb.push_back(e);
    step();
    req[ch]  = 1'b0;
    tail[ch] = 1'b0;
  endtask

  // Pop the oldest expectation and compare against the channel's output.
  task automatic expect_result(input int ch);
    int   waited;
    exp_t e;
    waited = 0;
    while (!valid[ch] && waited < 4) begin
      step();
      waited++;
    end
    chk("latency", 32'(waited), 32'd0);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("sb_ch", 32'(ch), 32'(e.ch));
      chk("mask",  32'(mask[ch]), 32'(e.mask));
      chk("local", 32'(loc[ch]), 32'(e.loc));
      chk("count", 32'(cnt[ch]), 32'(e.cnt));
      chk("err",   32'(rerr[ch]), 32'(e.err));
    end
  endtask

  task automatic ack_tail(input int ch);
    ack[ch]  = 1'b1;
    tail[ch] = 1'b1;
    step();
    ack[ch]  = 1'b0;
    tail[ch] = 1'b0;
    chk("single_flit_busy", 32'(busy[ch]), 32'd0);
    chk("single_flit_valid", 32'(valid[ch]), 32'd0);
  endtask

  vec_t tbl[10];
  exp_t e;

  initial begin
    tbl[0] = '{1, 2, 5, 6, 4'b0011, 0, 2, 0};
    tbl[1] = '{1, 0, 3, 1, 4'b0010, 0, 1, 0};
    tbl[2] = '{1, 0, 0, 5, 4'b1001, 0, 2, 0};
    tbl[3] = '{0, 0, 5, 6, 4'b0010, 0, 1, 0};
    tbl[4] = '{2, 0, 5, 6, 4'b0011, 0, 2, 0};
    tbl[5] = '{2, 0, 2, 3, 4'b0000, 1, 1, 0};
    tbl[6] = '{1, 0, 7, 1, 4'b0000, 0, 0, 1};
    tbl[7] = '{2, 0, 1, 2, 4'b1000, 0, 1, 0};
    tbl[8] = '{3, 0, 2, 6, 4'b0001, 0, 1, 0};
    tbl[9] = '{1, 0, 1, 1, 4'b1100, 0, 2, 0};

    reset = 1'b1;
    mode  = 2'd0;
    req   = '0;
    ack   = '0;
    tail  = '0;
    xsrc  = '0;
    xdst  = '0;
    ydst  = '0;
    repeat (3) step();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_mask",  32'(mask),  32'd0);
    chk("rst_reqerr", 32'(qerr), 32'd0);
    reset = 1'b0;
    step();

    // Directed route table, single-flit packets.
    for (int i = 0; i < 10; i++) begin
      e      = '0;
      e.ch   = 2'(i % NC);
      e.mask = 4'(tbl[i].mask);
      e.loc  = tbl[i].loc[0];
      e.cnt  = 3'(tbl[i].cnt);
      e.err  = tbl[i].err[0];
      issue(i % NC, tbl[i].md, tbl[i].xs, tbl[i].xd, tbl[i].yd, 1'b0, e);
      expect_result(i % NC);
      ack_tail(i % NC);
    end

    // Stall: withhold ack for five VALID cycles.
    issue(1, 1, 2, 5, 6, 1'b0, model(1, 1, 2, 5, 6));
    expect_result(1);
    for (int k = 1; k <= 5; k++) begin
      chk("stall", 32'(stall[1]), (k >= STH) ? 32'd1 : 32'd0);
      chk("stall_valid", 32'(valid[1]), 32'd1);
      if (k < 5) step();
    end
    ack[1] = 1'b1;
    step();
    ack[1] = 1'b0;
    chk("hold_valid", 32'(valid[1]), 32'd0);
    chk("hold_busy",  32'(busy[1]),  32'd1);
    chk("hold_stall", 32'(stall[1]), 32'd0);
    chk("hold_mask",  32'(mask[1]),  32'd3);

    // Request during HOLD is ignored and sets the sticky error.
    req[1] = 1'b1;
    step();
    req[1] = 1'b0;
    chk("reqerr_set",   32'(qerr[1]),  32'd1);
    chk("reqerr_valid", 32'(valid[1]), 32'd0);
    chk("reqerr_busy",  32'(busy[1]),  32'd1);
    chk("reqerr_other", 32'(qerr[2]),  32'd0);

    // Tail plus new request in the same cycle: back-to-back packet.
    issue(1, 0, 0, 0, 5, 1'b1, model(1, 0, 0, 0, 5));
    expect_result(1);
    ack_tail(1);
    chk("reqerr_sticky", 32'(qerr[1]), 32'd1);

    // Randomised routes across channels and modes.
    for (int i = 0; i < 24; i++) begin
      int ch, md, xs, xd, yd;
      ch = int'($urandom_range(0, NC - 1));
      md = int'($urandom_range(0, 3));
      xs = int'($urandom_range(0, XN - 1));
      xd = int'($urandom_range(0, 7));
      yd = int'($urandom_range(0, 7));
      issue(ch, md, xs, xd, yd, 1'b0, model(ch, md, xs, xd, yd));
      expect_result(ch);
      ack_tail(ch);
    end

    // Reset while a channel is in HOLD abandons the route.
    issue(0, 2, 0, 5, 6, 1'b0, model(0, 2, 0, 5, 6));
    expect_result(0);
    ack[0] = 1'b1;
    step();
    ack[0] = 1'b0;
    chk("pre_rst_busy", 32'(busy[0]), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy",  32'(busy),  32'd0);
    chk("midrst_mask",  32'(mask),  32'd0);
    chk("midrst_count", 32'(cnt),   32'd0);
    chk("midrst_reqerr", 32'(qerr), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
